// File: rtl/dual_dac_buffer.sv
// Double-buffered DAC waveform player. The MCU fills one buffer over the FSMC-style bus
// while the other streams to the DAC; committed waveforms swap in only at end-of-waveform.
module dual_dac_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int BUF_SIZE   = 1024,
    parameter int DAC_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  addr_en,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  dac_clk,
    output logic [DAC_WIDTH-1:0]  dac_data,
    output logic                  dac_active
);

    localparam int ADDR_W = $clog2(BUF_SIZE);
    localparam int LEN_W  = ADDR_W + 1;

    localparam logic [DATA_WIDTH-1:0] REG_STATUS = DATA_WIDTH'('h4000);
    localparam logic [DATA_WIDTH-1:0] REG_LEN    = DATA_WIDTH'('h4001);
    localparam logic [DATA_WIDTH-1:0] REG_CTRL   = DATA_WIDTH'('h4002);
    localparam logic [DATA_WIDTH-1:0] SIZE_D     = DATA_WIDTH'(BUF_SIZE);
    localparam logic [LEN_W-1:0]      SIZE_L     = LEN_W'(BUF_SIZE);
    localparam logic [DAC_WIDTH-1:0]  DAC_MID    = {1'b1, {(DAC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWITCH,
        S_PLAY
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_run;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_pend_len;
    logic [LEN_W-1:0]      r_play_len;
    logic                  r_swap_pending;
    logic                  r_play_buf;
    logic                  r_play_valid;
    logic [ADDR_W-1:0]     r_rd_ptr;
    logic                  r_dac_prev;
    logic [DAC_WIDTH-1:0]  r_rd_q;
    logic [DAC_WIDTH-1:0]  r_dac_data;
    logic                  r_dac_active;
    logic [DAC_WIDTH-1:0]  r_mem [0:2*BUF_SIZE-1];

    logic                  w_fill_free;
    logic                  w_is_sample;
    logic                  w_is_reg;
    logic                  w_bus_wr;
    logic                  w_bus_rd;
    logic                  w_sample_wr;
    logic                  w_commit;
    logic                  w_do_switch;
    logic                  w_dac_rise;
    logic                  w_last;
    logic [ADDR_W:0]       w_rd_addr;
    logic [DATA_WIDTH-1:0] w_rd_mux;

    // fill_free is always the complement of swap_pending, so one register holds both.
    assign w_fill_free = ~r_swap_pending;
    assign w_is_sample = (r_addr < SIZE_D);
    assign w_is_reg    = (r_addr == REG_STATUS) || (r_addr == REG_LEN) || (r_addr == REG_CTRL);
    assign w_bus_wr    = en & rd_en;
    assign w_bus_rd    = en & wr_en;
    assign w_sample_wr = w_bus_wr & w_is_sample & w_fill_free;
    assign w_commit    = w_bus_wr & (r_addr == REG_STATUS) & rd_data[0] & w_fill_free;
    assign w_do_switch = (r_state == S_SWITCH) & r_run;
    assign w_dac_rise  = dac_clk & ~r_dac_prev;
    assign w_last      = ({1'b0, r_rd_ptr} == (r_play_len - 1'b1));

    // During the swap cycle prefetch the new buffer's first sample so a dac_clk edge
    // arriving right after the swap never sees stale data.
    assign w_rd_addr   = w_do_switch ? {~r_play_buf, {ADDR_W{1'b0}}} : {r_play_buf, r_rd_ptr};

    assign wr_data    = r_wr_data;
    assign dac_data   = r_dac_data;
    assign dac_active = r_dac_active;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [DATA_WIDTH-1:0] v);
        if ((v == '0) || (v > SIZE_D)) return SIZE_L;
        return v[LEN_W-1:0];
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_rd_mux = '1;
        case (r_addr)
            REG_STATUS: w_rd_mux = DATA_WIDTH'({r_dac_active, r_swap_pending, w_fill_free});
            REG_LEN:    w_rd_mux = DATA_WIDTH'(r_len);
            REG_CTRL:   w_rd_mux = DATA_WIDTH'(r_run);
            default:    w_rd_mux = '1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr         <= '0;
            r_wr_data      <= '1;
            r_run          <= 1'b0;
            r_len          <= SIZE_L;
            r_pend_len     <= SIZE_L;
            r_swap_pending <= 1'b0;
        end else begin
            if (en && addr_en)
                r_addr <= rd_data;
            else if (w_bus_wr && !w_is_reg)
                r_addr <= r_addr + 1'b1;

            if (w_bus_rd)
                r_wr_data <= w_rd_mux;

            if (w_bus_wr && (r_addr == REG_LEN))
                r_len <= clamp_len(rd_data);
            if (w_bus_wr && (r_addr == REG_CTRL))
                r_run <= rd_data[0];

            if (w_do_switch) begin
                r_swap_pending <= 1'b0;
            end else if (w_commit) begin
                r_swap_pending <= 1'b1;
                r_pend_len     <= r_len;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_play_buf   <= 1'b0;
            r_play_len   <= SIZE_L;
            r_play_valid <= 1'b0;
            r_rd_ptr     <= '0;
            r_dac_prev   <= 1'b0;
            r_dac_data   <= DAC_MID;
            r_dac_active <= 1'b0;
        end else begin
            r_dac_prev <= dac_clk;
            if (!r_run) begin
                r_state      <= S_IDLE;
                r_rd_ptr     <= '0;
                r_dac_data   <= DAC_MID;
                r_dac_active <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_dac_data <= DAC_MID;
                        if (r_swap_pending) begin
                            r_state <= S_SWITCH;
                        end else if (r_play_valid) begin
                            r_state      <= S_PLAY;
                            r_dac_active <= 1'b1;
                        end
                    end
                    S_SWITCH: begin
                        r_play_buf   <= ~r_play_buf;
                        r_play_len   <= r_pend_len;
                        r_play_valid <= 1'b1;
                        r_rd_ptr     <= '0;
                        r_state      <= S_PLAY;
                        r_dac_active <= 1'b1;
                    end
                    S_PLAY: begin
                        if (w_dac_rise) begin
                            r_dac_data <= r_rd_q;
                            if (w_last) begin
                                if (r_swap_pending) begin
                                    r_state      <= S_SWITCH;
                                    r_dac_active <= 1'b0;
                                end else begin
                                    r_rd_ptr <= '0;
                                end
                            end else begin
                                r_rd_ptr <= r_rd_ptr + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state      <= S_IDLE;
                        r_dac_active <= 1'b0;
                    end
                endcase
            end
        end
    end

    // NOTE: the sample RAM and its read register are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_sample_wr)
            r_mem[{~r_play_buf, r_addr[ADDR_W-1:0]}] <= rd_data[DAC_WIDTH-1:0];
        r_rd_q <= r_mem[w_rd_addr];
    end

endmodule

// File: tb/tb_dual_dac_buffer.sv
// Directed bench for dual_dac_buffer: table of bus/dac_clk operations with expected
// readback and DAC values, plus hand sequences for swap-at-boundary, run stop and reset.
module tb_dual_dac_buffer;

    localparam logic [15:0] A_STATUS = 16'h4000;
    localparam logic [15:0] A_LEN    = 16'h4001;
    localparam logic [15:0] A_CTRL   = 16'h4002;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        addr_en;
    logic        rd_en;
    logic        wr_en;
    logic [15:0] rd_data;
    logic [15:0] wr_data;
    logic        dac_clk;
    logic [11:0] dac_data;
    logic        dac_active;

    int total = 0;
    int bad   = 0;
    logic [15:0] got;

    typedef enum {OP_RD, OP_WR, OP_BURST, OP_TICK, OP_IDLE} op_e;
    typedef struct {
        op_e         op;
        logic [15:0] addr;
        logic [15:0] data;
        int          cnt;
        logic [15:0] exp;
        logic [11:0] exp_dac;
    } vec_t;
    vec_t vecs[$];

    dual_dac_buffer #(.DATA_WIDTH(16), .BUF_SIZE(1024), .DAC_WIDTH(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .addr_en    (addr_en),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .rd_data    (rd_data),
        .wr_data    (wr_data),
        .dac_clk    (dac_clk),
        .dac_data   (dac_data),
        .dac_active (dac_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_addr(input logic [15:0] a);
        en = 1'b1; addr_en = 1'b1; rd_data = a;
        step();
        addr_en = 1'b0; en = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        bus_addr(a);
        en = 1'b1; rd_en = 1'b1; rd_data = d;
        step();
        rd_en = 1'b0; en = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        bus_addr(a);
        en = 1'b1; wr_en = 1'b1;
        step();
        wr_en = 1'b0; en = 1'b0;
        d = wr_data;
    endtask

    task automatic burst(input logic [15:0] a, input logic [15:0] d, input int n);
        bus_addr(a);
        en = 1'b1; rd_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            rd_data = d + 16'(i);
            step();
        end
        rd_en = 1'b0; en = 1'b0;
    endtask

    task automatic dac_tick();
        dac_clk = 1'b1;
        step();
        step();
        dac_clk = 1'b0;
        step();
        step();
    endtask

    task automatic v_rd(input logic [15:0] a, input logic [15:0] e, input logic [11:0] dv);
        vecs.push_back('{op: OP_RD, addr: a, data: 16'h0, cnt: 0, exp: e, exp_dac: dv});
    endtask
    task automatic v_wr(input logic [15:0] a, input logic [15:0] d, input logic [11:0] dv);
        vecs.push_back('{op: OP_WR, addr: a, data: d, cnt: 0, exp: 16'h0, exp_dac: dv});
    endtask
    task automatic v_burst(input logic [15:0] a, input logic [15:0] d, input int n, input logic [11:0] dv);
        vecs.push_back('{op: OP_BURST, addr: a, data: d, cnt: n, exp: 16'h0, exp_dac: dv});
    endtask
    task automatic v_tick(input logic [11:0] dv);
        vecs.push_back('{op: OP_TICK, addr: 16'h0, data: 16'h0, cnt: 0, exp: 16'h0, exp_dac: dv});
    endtask
    task automatic v_idle(input int n, input logic [11:0] dv);
        vecs.push_back('{op: OP_IDLE, addr: 16'h0, data: 16'h0, cnt: n, exp: 16'h0, exp_dac: dv});
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; addr_en = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        rd_data = 16'h0; dac_clk = 1'b0;

        // Reset state, run without commit, first waveform 0..7.
        v_rd(A_STATUS, 16'h0001, 12'h800);
        v_rd(A_LEN,    16'h0400, 12'h800);
        v_rd(A_CTRL,   16'h0000, 12'h800);
        v_rd(16'h0000, 16'hFFFF, 12'h800);
        v_rd(16'h4003, 16'hFFFF, 12'h800);
        v_wr(A_CTRL, 16'h0001, 12'h800);
        v_idle(4, 12'h800);
        v_rd(A_STATUS, 16'h0001, 12'h800);
        v_rd(A_CTRL,   16'h0001, 12'h800);
        v_tick(12'h800);
        v_burst(16'h0000, 16'h0000, 8, 12'h800);
        v_wr(A_LEN, 16'h0008, 12'h800);
        v_rd(A_LEN, 16'h0008, 12'h800);
        v_wr(A_STATUS, 16'h0001, 12'h800);
        v_idle(4, 12'h800);
        v_rd(A_STATUS, 16'h0005, 12'h800);
        for (int i = 0; i < 10; i++) v_tick(12'(i % 8));

        // Second waveform committed mid-play; extra commit and fills while pending dropped.
        v_burst(16'h0000, 16'd100, 4, 12'd1);
        v_wr(A_LEN, 16'h0004, 12'd1);
        v_tick(12'd2);
        v_tick(12'd3);
        v_wr(A_STATUS, 16'h0001, 12'd3);
        v_rd(A_STATUS, 16'h0006, 12'd3);
        v_wr(A_STATUS, 16'h0001, 12'd3);
        v_burst(16'h0000, 16'd200, 4, 12'd3);
        v_wr(A_LEN, 16'h0002, 12'd3);
        v_rd(A_LEN, 16'h0002, 12'd3);
        v_rd(A_STATUS, 16'h0006, 12'd3);
        for (int i = 4; i < 8; i++) v_tick(12'(i));
        v_idle(2, 12'd7);
        v_rd(A_STATUS, 16'h0005, 12'd7);
        for (int i = 0; i < 5; i++) v_tick(12'(100 + (i % 4)));

        // LEN clamping boundaries.
        v_wr(A_LEN, 16'd0, 12'd100);
        v_rd(A_LEN, 16'h0400, 12'd100);
        v_wr(A_LEN, 16'd5000, 12'd100);
        v_rd(A_LEN, 16'h0400, 12'd100);
        v_wr(A_LEN, 16'd1025, 12'd100);
        v_rd(A_LEN, 16'h0400, 12'd100);
        v_wr(A_LEN, 16'd1024, 12'd100);
        v_rd(A_LEN, 16'h0400, 12'd100);
        v_wr(A_LEN, 16'd1023, 12'd100);
        v_rd(A_LEN, 16'h03FF, 12'd100);
        v_tick(12'd101);

        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("reset dac_data", 16'(dac_data), 16'h0800);
        check("reset wr_data", wr_data, 16'hFFFF);
        check("reset dac_active", 16'(dac_active), 16'h0000);

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_RD: begin
                    bus_read(vecs[i].addr, got);
                    check($sformatf("v%0d read %h", i, vecs[i].addr), got, vecs[i].exp);
                end
                OP_WR:    bus_write(vecs[i].addr, vecs[i].data);
                OP_BURST: burst(vecs[i].addr, vecs[i].data, vecs[i].cnt);
                OP_TICK:  dac_tick();
                OP_IDLE:  repeat (vecs[i].cnt) step();
                default:  ;
            endcase
            check($sformatf("v%0d dac_data", i), 16'(dac_data), 16'(vecs[i].exp_dac));
        end
        check("playing dac_active", 16'(dac_active), 16'h0001);

        // run cleared mid-waveform: mid-scale output, then restart from index 0.
        bus_write(A_CTRL, 16'h0000);
        step();
        check("stop dac_data", 16'(dac_data), 16'h0800);
        check("stop dac_active", 16'(dac_active), 16'h0000);
        bus_read(A_STATUS, got);
        check("stop status", got, 16'h0001);
        bus_write(A_CTRL, 16'h0001);
        repeat (2) step();
        for (int i = 0; i < 5; i++) begin
            dac_tick();
            check($sformatf("restart tick %0d", i), 16'(dac_data), 16'(100 + (i % 4)));
        end

        // COMMIT on the same clock as the final sample: old waveform plays once more.
        burst(16'h0000, 16'd50, 2);
        bus_write(A_LEN, 16'h0002);
        dac_tick();
        check("pre-edge tick 1", 16'(dac_data), 16'd101);
        dac_tick();
        check("pre-edge tick 2", 16'(dac_data), 16'd102);
        bus_addr(A_STATUS);
        en = 1'b1; rd_en = 1'b1; rd_data = 16'h0001; dac_clk = 1'b1;
        step();
        rd_en = 1'b0; en = 1'b0;
        step();
        dac_clk = 1'b0;
        step();
        step();
        check("edge commit sample", 16'(dac_data), 16'd103);
        dac_tick();
        check("repeat tick 0", 16'(dac_data), 16'd100);
        bus_read(A_STATUS, got);
        check("edge commit pending", got, 16'h0006);
        for (int i = 1; i < 4; i++) begin
            dac_tick();
            check($sformatf("repeat tick %0d", i), 16'(dac_data), 16'(100 + i));
        end
        for (int i = 0; i < 3; i++) begin
            dac_tick();
            check($sformatf("new wave tick %0d", i), 16'(dac_data), 16'(50 + (i % 2)));
        end

        // One-cycle reset while playing.
        rst_n = 1'b0;
        step();
        check("midplay reset dac_data", 16'(dac_data), 16'h0800);
        check("midplay reset wr_data", wr_data, 16'hFFFF);
        check("midplay reset dac_active", 16'(dac_active), 16'h0000);
        rst_n = 1'b1;
        bus_read(A_STATUS, got);
        check("post reset status", got, 16'h0001);
        bus_read(A_LEN, got);
        check("post reset len", got, 16'h0400);
        dac_tick();
        check("post reset tick", 16'(dac_data), 16'h0800);

        // Bus actions without chip-select are ignored.
        addr_en = 1'b1; rd_data = A_CTRL;
        step();
        addr_en = 1'b0; rd_en = 1'b1; rd_data = 16'h0001;
        step();
        rd_en = 1'b0;
        bus_read(A_CTRL, got);
        check("en gated write", got, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
